iis_tx_fifo: RTL and testbench

Dual-clock sample buffer that sits directly upstream of the I2S transmitter. The APB side writes 16-bit audio samples in the bus clock domain. The transmitter pops samples in the serial-clock domain using its read clock and read-enable outputs. Full/empty and fill-level status use Gray-coded pointers with two-flop synchronizers, so both clocks may be fully asynchronous.

---
 rtl/iis_tx_fifo_if.sv | 34 +++
 rtl/iis_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_iis_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iis_tx_fifo_if.sv
// Sample-buffer bus between the APB writer, the I2S transmitter reader and the
// dual-clock FIFO.
interface iis_tx_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    // Handshake: a push completes on a wr_clk edge where wr_en=1 and full=0; a pop
    // completes on an rd_clk edge where rd_en=1 and empty=0, and rd_data is valid
    // from that same edge. A request made against the flag sets a sticky error bit.
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, wr_count, overflow,
        input  rd_data, empty, almost_empty, rd_count, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, wr_count, overflow,
        output rd_data, empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/iis_tx_fifo.sv
// Dual-clock sample FIFO feeding the I2S transmitter; Gray pointers cross
// domains through two-flop synchronizers so both clocks may be unrelated.
module iis_tx_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 6,
    parameter int AFULL_LEVEL  = 56,
    parameter int AEMPTY_LEVEL = 8
) (
    input  logic           wr_clk,
    input  logic           rd_clk,
    input  logic           rst,
    iis_tx_fifo_if.slave   bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write domain
    logic [PW-1:0] r_wr_bin;
    logic [PW-1:0] r_wr_gray;
    logic [PW-1:0] r_rq1;
    logic [PW-1:0] r_rq2;
    logic [PW-1:0] r_wr_count;
    logic          r_full;
    logic          r_afull;
    logic          r_overflow;

    logic          w_wr_inc;
    logic [PW-1:0] w_wr_bin_nxt;
    logic [PW-1:0] w_wr_gray_nxt;
    logic [PW-1:0] w_rq_bin;
    logic [PW-1:0] w_wr_count_nxt;
    logic          w_full_nxt;

    // Read domain
    logic [PW-1:0]         r_rd_bin;
    logic [PW-1:0]         r_rd_gray;
    logic [PW-1:0]         r_wq1;
    logic [PW-1:0]         r_wq2;
    logic [PW-1:0]         r_rd_count;
    logic                  r_empty;
    logic                  r_aempty;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic          w_rd_inc;
    logic [PW-1:0] w_rd_bin_nxt;
    logic [PW-1:0] w_rd_gray_nxt;
    logic [PW-1:0] w_wq_bin;
    logic [PW-1:0] w_rd_count_nxt;
    logic          w_empty_nxt;

    assign w_wr_inc       = bus.wr_en & ~r_full;
    assign w_wr_bin_nxt   = r_wr_bin + PW'(w_wr_inc);
    assign w_wr_gray_nxt  = bin2gray(w_wr_bin_nxt);
    assign w_rq_bin       = gray2bin(r_rq2);
    assign w_wr_count_nxt = w_wr_bin_nxt - w_rq_bin;
    // Full when the write pointer is exactly one lap ahead of the synced read pointer.
    assign w_full_nxt     = (w_wr_gray_nxt == {~r_rq2[PW-1:PW-2], r_rq2[PW-3:0]});

    always_ff @(posedge wr_clk) begin
        if (w_wr_inc) begin
            r_mem[r_wr_bin[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_wr_bin   <= '0;
            r_wr_gray  <= '0;
            r_rq1      <= '0;
            r_rq2      <= '0;
            r_wr_count <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_bin   <= w_wr_bin_nxt;
            r_wr_gray  <= w_wr_gray_nxt;
            r_rq1      <= r_rd_gray;
            r_rq2      <= r_rq1;
            r_wr_count <= w_wr_count_nxt;
            r_full     <= w_full_nxt;
            r_afull    <= (w_wr_count_nxt >= PW'(AFULL_LEVEL));
            if (bus.wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_rd_inc       = bus.rd_en & ~r_empty;
    assign w_rd_bin_nxt   = r_rd_bin + PW'(w_rd_inc);
    assign w_rd_gray_nxt  = bin2gray(w_rd_bin_nxt);
    assign w_wq_bin       = gray2bin(r_wq2);
    assign w_rd_count_nxt = w_wq_bin - w_rd_bin_nxt;
    assign w_empty_nxt    = (w_rd_gray_nxt == r_wq2);

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_rd_bin    <= '0;
            r_rd_gray   <= '0;
            r_wq1       <= '0;
            r_wq2       <= '0;
            r_rd_count  <= '0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_underflow <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_bin   <= w_rd_bin_nxt;
            r_rd_gray  <= w_rd_gray_nxt;
            r_wq1      <= r_wr_gray;
            r_wq2      <= r_wq1;
            r_rd_count <= w_rd_count_nxt;
            r_empty    <= w_empty_nxt;
            r_aempty   <= (w_rd_count_nxt <= PW'(AEMPTY_LEVEL));
            if (w_rd_inc) begin
                r_rd_data <= r_mem[r_rd_bin[ADDR_WIDTH-1:0]];
            end
            if (bus.rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.full         = r_full;
    assign bus.almost_full  = r_afull;
    assign bus.wr_count     = r_wr_count;
    assign bus.overflow     = r_overflow;
    assign bus.rd_data      = r_rd_data;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_aempty;
    assign bus.rd_count     = r_rd_count;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_iis_tx_fifo.sv
// Directed and streaming checks of iis_tx_fifo against a queue of expected samples.
module tb_iis_tx_fifo;
    localparam int DW = 16;
    localparam int AW = 6;

    logic wr_clk = 1'b0;
    logic rd_clk = 1'b0;
    logic rst    = 1'b0;
    int   rd_half = 163;

    always #10 wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    iis_tx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    iis_tx_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(56), .AEMPTY_LEVEL(8)
    ) dut (
        .wr_clk (wr_clk),
        .rd_clk (rd_clk),
        .rst    (rst),
        .bus    (bus)
    );

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_exp;
    int n_cmp = 0;
    int n_mis = 0;
    int n_wr, n_rd, wbudget, rbudget, lat;
    bit acc, got, wacc, rgot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_push(input logic [DW-1:0] d, input bit force_en, output bit accepted);
        @(negedge wr_clk);
        accepted = !bus.full;
        if (force_en || accepted) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = d;
        end
        @(posedge wr_clk);
        #1;
        bus.wr_en = 1'b0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic rd_pop(input string tag, input bit force_en, output bit popped);
        logic [DW-1:0] e;
        @(negedge rd_clk);
        popped = !bus.empty;
        if (force_en || popped) bus.rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        bus.rd_en = 1'b0;
        if (popped) begin
            check({tag, "_avail"}, 32'(exp_q.size() != 0), 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            last_exp = e;
            check(tag, bus.rd_data, e);
        end else if (force_en) begin
            check({tag, "_hold"}, bus.rd_data, last_exp);
        end
    endtask

    task automatic wait_not_empty(input string tag);
        for (int k = 0; k < 16; k++) begin
            @(posedge rd_clk);
            #1;
            if (!bus.empty) break;
        end
        check(tag, bus.empty, 0);
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        rst = 1'b1;
        @(negedge wr_clk);
        rst = 1'b0;
        exp_q.delete();
        last_exp = '0;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        last_exp    = '0;
        #5 rst = 1'b1;
        repeat (3) @(negedge wr_clk);
        rst = 1'b0;
        #1;
        check("rst_full", bus.full, 0);
        check("rst_afull", bus.almost_full, 0);
        check("rst_wr_count", bus.wr_count, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_aempty", bus.almost_empty, 1);
        check("rst_rd_count", bus.rd_count, 0);
        check("rst_underflow", bus.underflow, 0);
        check("rst_rd_data", bus.rd_data, 0);

        // Test 1: three samples, slow serial clock
        wr_push(16'h0001, 1, acc);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge rd_clk);
            #1;
            lat++;
            if (!bus.empty) break;
        end
        check("t1_empty_lat_ok", 32'(lat >= 2 && lat <= 3), 1);
        check("t1_empty", bus.empty, 0);
        check("t1_rd_count1", bus.rd_count, 1);
        wr_push(16'h0002, 1, acc);
        wr_push(16'h0003, 1, acc);
        repeat (4) @(posedge rd_clk);
        #1;
        check("t1_rd_count3", bus.rd_count, 3);
        for (int k = 0; k < 3; k++) begin
            rd_pop("t1_pop", 1, got);
            check("t1_got", got, 1);
        end
        check("t1_empty_end", bus.empty, 1);
        check("t1_rd_count_end", bus.rd_count, 0);
        check("t1_underflow", bus.underflow, 0);

        // Test 2: fill to full, overflow, drain in order
        repeat (4) @(posedge wr_clk);
        for (int k = 1; k <= 64; k++) begin
            wr_push(16'($urandom_range(0, 65535)), 1, acc);
            if (k == 55) begin
                check("t2_afull55", bus.almost_full, 0);
                check("t2_count55", bus.wr_count, 55);
            end
            if (k == 56) check("t2_afull56", bus.almost_full, 1);
            if (k == 63) check("t2_full63", bus.full, 0);
        end
        check("t2_full", bus.full, 1);
        check("t2_wr_count", bus.wr_count, 64);
        check("t2_overflow0", bus.overflow, 0);
        wr_push(16'hDEAD, 1, acc);
        check("t2_overflow1", bus.overflow, 1);
        check("t2_full_after", bus.full, 1);
        check("t2_wr_count_after", bus.wr_count, 64);
        repeat (4) @(posedge rd_clk);
        #1;
        check("t2_rd_count", bus.rd_count, 64);
        check("t2_aempty", bus.almost_empty, 0);
        for (int k = 0; k < 64; k++) begin
            rd_pop("t2_pop", 1, got);
            check("t2_got", got, 1);
        end
        check("t2_empty_end", bus.empty, 1);

        // Test 3: underflow
        rd_pop("t3_under", 1, got);
        check("t3_got", got, 0);
        check("t3_underflow", bus.underflow, 1);
        check("t3_rd_count", bus.rd_count, 0);
        wr_push(16'hBEEF, 1, acc);
        wait_not_empty("t3_wait");
        rd_pop("t3_pop", 1, got);
        check("t3_underflow_sticky", bus.underflow, 1);

        // Test 4: concurrent random stream of 1000 samples
        do_reset();
        rd_half = 17;
        repeat (4) @(posedge rd_clk);
        #1;
        check("t4_overflow_clr", bus.overflow, 0);
        check("t4_underflow_clr", bus.underflow, 0);
        n_wr = 0; n_rd = 0; wbudget = 0; rbudget = 0;
        fork
            begin
                while (n_wr < 1000 && wbudget < 20000) begin
                    wbudget++;
                    if ($urandom_range(0, 1) != 0) begin
                        wr_push(16'(n_wr), 0, wacc);
                        if (wacc) n_wr++;
                    end else begin
                        @(posedge wr_clk);
                    end
                end
            end
            begin
                while (n_rd < 1000 && rbudget < 20000) begin
                    rbudget++;
                    if ($urandom_range(0, 3) != 0) begin
                        rd_pop("t4_stream", 0, rgot);
                        if (rgot) n_rd++;
                    end else begin
                        @(posedge rd_clk);
                    end
                end
            end
        join
        check("t4_n_written", n_wr, 1000);
        check("t4_n_read", n_rd, 1000);
        check("t4_overflow", bus.overflow, 0);
        check("t4_underflow", bus.underflow, 0);

        // Test 5: reset mid-stream
        rd_pop("t5_pre", 1, got);
        check("t5_underflow_set", bus.underflow, 1);
        for (int k = 0; k < 20; k++) wr_push(16'(16'hA000 + k), 1, acc);
        @(negedge wr_clk);
        rst = 1'b1;
        #1;
        check("t5_empty", bus.empty, 1);
        check("t5_full", bus.full, 0);
        check("t5_wr_count", bus.wr_count, 0);
        check("t5_rd_count", bus.rd_count, 0);
        check("t5_underflow", bus.underflow, 0);
        check("t5_overflow", bus.overflow, 0);
        check("t5_aempty", bus.almost_empty, 1);
        check("t5_rd_data", bus.rd_data, 0);
        @(negedge wr_clk);
        rst = 1'b0;
        exp_q.delete();
        last_exp = '0;
        wr_push(16'h1234, 1, acc);
        wait_not_empty("t5_wait");
        rd_pop("t5_pop", 1, got);
        check("t5_empty_end", bus.empty, 1);

        // Test 6: full release latency and almost_empty threshold
        repeat (4) @(posedge wr_clk);
        for (int k = 0; k < 64; k++) wr_push(16'($urandom_range(0, 65535)), 1, acc);
        check("t6_full", bus.full, 1);
        check("t6_wr_count64", bus.wr_count, 64);
        repeat (4) @(posedge rd_clk);
        #1;
        check("t6_rd_count64", bus.rd_count, 64);
        rd_pop("t6_pop1", 1, got);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge wr_clk);
            #1;
            lat++;
            if (!bus.full) break;
        end
        check("t6_full_lat_ok", 32'(lat >= 2 && lat <= 3), 1);
        check("t6_full_clr", bus.full, 0);
        check("t6_wr_count63", bus.wr_count, 63);
        repeat (4) @(posedge rd_clk);
        for (int k = 1; k <= 63; k++) begin
            rd_pop("t6_drain", 1, got);
            check("t6_rd_count", bus.rd_count, 63 - k);
            check("t6_aempty", bus.almost_empty, 32'((63 - k) <= 8));
        end
        check("t6_empty_end", bus.empty, 1);
        check("t6_underflow", bus.underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
